// File: rtl/key_expand_iter_pkg.sv
// rtl/key_expand_iter_pkg.sv - shared constants, state type and helpers for the AES key schedule
// Purpose: key-size encodings, Nk / total-word lookups, expanded-key width, xtime.
// Ports: none (package).
package key_expand_iter_pkg;

  localparam logic [2:0] KEY128 = 3'b001;
  localparam logic [2:0] KEY192 = 3'b010;
  localparam logic [2:0] KEY256 = 3'b100;

  localparam int EXPKEY_W = 1920;

  localparam logic [3:0] NK128 = 4'd4;
  localparam logic [3:0] NK192 = 4'd6;
  localparam logic [3:0] NK256 = 4'd8;

  localparam logic [5:0] T128 = 6'd44;
  localparam logic [5:0] T192 = 6'd52;
  localparam logic [5:0] T256 = 6'd60;

  typedef enum logic {IDLE, RUN} state_e;

  // Non one-hot encodings fall back to 128-bit.
  function automatic logic [3:0] nk_of(input logic [2:0] ks);
    case (ks)
      KEY192:  return NK192;
      KEY256:  return NK256;
      default: return NK128;
    endcase
  endfunction

  function automatic logic [5:0] t_of(input logic [2:0] ks);
    case (ks)
      KEY192:  return T192;
      KEY256:  return T256;
      default: return T128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expand_iter_if.sv
// rtl/key_expand_iter_if.sv - control and key-vector bundle for the key schedule
// Purpose: groups start/key/keySize requests and busy/keyValid/keyExp results.
// Ports: master drives start, key, keySize; slave drives busy, keyValid, keyExp.
interface key_expand_iter_if;
  import key_expand_iter_pkg::*;

  logic                  start;
  logic [0:255]          key;
  logic [2:0]            keySize;
  logic                  busy;
  logic                  keyValid;
  logic [0:EXPKEY_W-1]   keyExp;

  modport master (output start, key, keySize, input busy, keyValid, keyExp);
  modport slave  (input start, key, keySize, output busy, keyValid, keyExp);
endinterface

// File: rtl/key_expand_iter_aes_sbox.sv
// rtl/key_expand_iter_aes_sbox.sv - combinational AES forward S-box
// Purpose: 8-bit byte substitution, shared by SubWord and the forward rounds.
// Ports: din (8-bit byte in), dout (substituted byte out).
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Table stored big-endian: entry n occupies bits [8n : 8n+7].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[{din, 3'b000} +: 8];

endmodule

// File: rtl/key_expand_iter.sv
// rtl/key_expand_iter.sv - iterative AES-128/192/256 key expansion, one word per clock
// Purpose: loads the cipher key, then generates w[Nk..T-1] into a flat 60-word vector.
// Ports: clk, rst (async active-high), bus (slave: start/key/keySize in,
//        busy/keyValid/keyExp out).
module key_expand_iter
  import key_expand_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  key_expand_iter_if.slave  bus
);

  state_e                state;
  logic [3:0]            nk;
  logic [5:0]            tw;
  logic [5:0]            idx;
  logic [2:0]            kmod;
  logic [7:0]            rcon;
  logic                  busy_q;
  logic                  valid_q;
  logic [0:EXPKEY_W-1]   w_q;

  logic [3:0]  start_nk;
  logic [5:0]  prev_idx;
  logic [5:0]  back_idx;
  logic [31:0] prev_w;
  logic [31:0] back_w;
  logic [31:0] sb_in;
  logic [31:0] sub_w;
  logic [31:0] temp_w;
  logic [31:0] next_w;
  logic        last;

  assign start_nk = nk_of(bus.keySize);
  assign prev_idx = idx - 6'd1;
  assign back_idx = idx - {2'b00, nk};
  assign prev_w   = w_q[{prev_idx, 5'b00000} +: 32];
  assign back_w   = w_q[{back_idx, 5'b00000} +: 32];
  // RotWord only on the rcon step; the 256-bit mid-block step substitutes unrotated.
  assign sb_in    = (kmod == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign last     = (idx == tw - 6'd1);

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.din(sb_in[8*g +: 8]), .dout(sub_w[8*g +: 8]));
  end

  always_comb begin
    temp_w = prev_w;
    if (kmod == 3'd0)
      temp_w = sub_w ^ {rcon, 24'h000000};
    else if (nk == NK256 && kmod == 3'd4)
      temp_w = sub_w;
    next_w = back_w ^ temp_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      nk      <= NK128;
      tw      <= T128;
      idx     <= 6'd0;
      kmod    <= 3'd0;
      rcon    <= 8'h01;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      w_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            nk <= start_nk;
            tw <= t_of(bus.keySize);
            w_q <= '0;
            for (int j = 0; j < 8; j++) begin
              if (4'(j) < start_nk)
                w_q[32*j +: 32] <= bus.key[32*j +: 32];
            end
            idx     <= {2'b00, start_nk};
            kmod    <= 3'd0;
            rcon    <= 8'h01;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          w_q[{idx, 5'b00000} +: 32] <= next_w;
          if (kmod == 3'd0)
            rcon <= xtime(rcon);
          idx  <= idx + 6'd1;
          kmod <= ({1'b0, kmod} == nk - 4'd1) ? 3'd0 : kmod + 3'd1;
          if (last) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.keyValid = valid_q;
  assign bus.keyExp   = w_q;

endmodule

// File: tb/tb_key_expand_iter.sv
// tb/tb_key_expand_iter.sv - directed FIPS-197 vector bench for key_expand_iter
module tb_key_expand_iter;
  import key_expand_iter_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;

  key_expand_iter_if bus ();

  key_expand_iter dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'h0123456789abcdeffedcba9876543210};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hdeadbeefcafef00d};
  localparam logic [0:255] K256 = {256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return bus.keyExp[32*i +: 32];
  endfunction

  function automatic logic [31:0] tail_nz(input int from);
    logic any;
    any = 1'b0;
    for (int i = from; i < 60; i++) any |= |bus.keyExp[32*i +: 32];
    return {31'b0, any};
  endfunction

  // Issues start, then counts edges until keyValid is seen. At edge pulse_at a stray
  // start plus altered key/keySize is applied for one cycle (0 disables).
  task automatic do_run(input logic [0:255] k, input logic [2:0] ks, input int pulse_at,
                        output int n);
    @(negedge clk);
    bus.key = k;
    bus.keySize = ks;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("accept_busy", {31'b0, bus.busy}, 32'd1);
    chk("accept_drop", {31'b0, bus.keyValid}, 32'd0);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.keyValid) break;
      if (n == pulse_at) begin
        bus.start = 1'b1;
        bus.keySize = KEY256;
        bus.key = ~k;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("done_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic chk_a1(input string tag);
    chk({tag, "_w0"}, wd(0), 32'h2b7e1516);
    chk({tag, "_w4"}, wd(4), 32'ha0fafe17);
    chk({tag, "_w43"}, wd(43), 32'hb6630ca6);
    chk({tag, "_tail"}, tail_nz(44), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.keySize = KEY128;
    #12;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_valid", {31'b0, bus.keyValid}, 32'd0);
    chk("rst_exp", tail_nz(0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_run(K128, KEY128, 0, lat);
    chk("a1_lat", 32'(lat), 32'd40);
    chk_a1("a1");
    repeat (3) @(posedge clk);
    #1;
    chk("a1_hold_valid", {31'b0, bus.keyValid}, 32'd1);
    chk("a1_hold_w43", wd(43), 32'hb6630ca6);

    do_run(K192, KEY192, 0, lat);
    chk("a2_lat", 32'(lat), 32'd46);
    chk("a2_w6", wd(6), 32'hfe0c91f7);
    chk("a2_w51", wd(51), 32'h01002202);
    chk("a2_tail", tail_nz(52), 32'd0);

    do_run(K256, KEY256, 0, lat);
    chk("a3_lat", 32'(lat), 32'd52);
    chk("a3_w8", wd(8), 32'h9ba35411);
    chk("a3_w59", wd(59), 32'h706c631e);

    // Back-to-back: start issued in the cycle right after the completion edge.
    do_run(K128, KEY128, 0, lat);
    chk("b2b_lat", 32'(lat), 32'd40);
    chk_a1("b2b");

    do_run(K128, KEY128, 10, lat);
    chk("pulse_lat", 32'(lat), 32'd40);
    chk_a1("pulse");

    do_run(K128, 3'b111, 0, lat);
    chk("ks111_lat", 32'(lat), 32'd40);
    chk_a1("ks111");

    // Reset on cycle 20 of a 256-bit run.
    @(negedge clk);
    bus.key = K256;
    bus.keySize = KEY256;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mrst_valid", {31'b0, bus.keyValid}, 32'd0);
    chk("mrst_exp", tail_nz(0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_novalid", {31'b0, bus.keyValid}, 32'd0);

    do_run(K128, KEY128, 0, lat);
    chk("post_rst_lat", 32'(lat), 32'd40);
    chk_a1("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
